ram_fsm_top: RTL and testbench

LED pattern sequencer: a state machine fills an internal 16-word pattern RAM after reset, then steps through it at a prescaled rate while enabled. Each word drives two 4-bit LED banks. This is the board-level top of the RAM/FSM design; the clock comes from the 100 MHz board oscillator.

---
 rtl/ram_fsm_pkg.sv | 25 ++
 rtl/led_pattern_ram.sv | 23 ++
 rtl/ram_fsm_top.sv | 120 ++++++++++++
 tb/tb_ram_fsm_top.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ram_fsm_pkg.sv
// Shared types and sizes for the LED pattern sequencer.
// Contents: FSM state enum, RAM geometry, and the pattern-word generator
// used by the INIT fill.
package ram_fsm_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int WORD_W = 8;
  localparam int LED_W  = 4;

  // Pattern word for address k: {led_r = k, leds = one-hot walking bit}.
  function automatic logic [WORD_W-1:0] init_word(input logic [ADDR_W-1:0] k);
    logic [LED_W-1:0] leds;
    leds = LED_W'(1) << k[1:0];
    return {k, leds};
  endfunction

endpackage

// File: rtl/led_pattern_ram.sv
// Single-port 16x8 pattern RAM with registered, read-first output.
// Ports: clock; we/addr/wdata write port; rdata = mem[addr] captured each edge.
// No reset: contents are rewritten by the INIT fill after every reset.
module led_pattern_ram
  import ram_fsm_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/ram_fsm_top.sv
// LED pattern sequencer: fills a 16-word RAM after reset, then steps through
// it, showing each word for PRESCALE cycles while i_enable is high.
// Ports: clock, i_reset (async, active-high), i_enable (run/pause),
// o_led_r / o_leds (registered 4-bit LED banks).
module ram_fsm_top
  import ram_fsm_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  output logic [3:0] o_led_r,
  output logic [3:0] o_leds
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LED_W-1:0]   led_r_q, led_r_d;
  logic [LED_W-1:0]   leds_q, leds_d;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [WORD_W-1:0]  ram_wdata;
  logic [WORD_W-1:0]  ram_rdata;

  // The RAM is addressed with next-state addr, so its registered rdata always
  // holds mem[addr_q]. That lets the output register load "ram[addr]" on the
  // same edge without an extra pipeline stage. During INIT it follows wcnt.
  assign ram_addr  = (state_q == INIT) ? wcnt_q : addr_d;
  assign ram_wdata = init_word(wcnt_q);

  led_pattern_ram u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    led_r_d = led_r_q;
    leds_d  = leds_q;
    ram_we  = 1'b0;

    case (state_q)
      INIT: begin
        ram_we  = 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        led_r_d = '0;
        leds_d  = '0;
        if (wcnt_q == ADDR_LAST) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        led_r_d = '0;
        leds_d  = '0;
        addr_d  = '0;
        cnt_d   = '0;
        if (i_enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // This edge always acts as a RUN edge, even when enable just dropped.
        {led_r_d, leds_d} = ram_rdata;
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          addr_d = addr_q + 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
        end
        if (!i_enable) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_enable) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= INIT;
      wcnt_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      led_r_q <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      led_r_q <= led_r_d;
      leds_q  <= leds_d;
    end
  end

  assign o_led_r = led_r_q;
  assign o_leds  = leds_q;

endmodule

// File: tb/tb_ram_fsm_top.sv
// Self-checking bench for ram_fsm_top with PRESCALE = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_fsm_top;

  logic       clock = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic [3:0] o_led_r;
  logic [3:0] o_leds;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  ram_fsm_top #(.PRESCALE(4)) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_led_r  (o_led_r),
    .o_leds   (o_leds)
  );

  typedef struct {
    logic       en;
    logic [3:0] r;
    logic [3:0] l;
  } vec_t;

  vec_t tbl [70];

  task automatic check(input string name, input logic [3:0] er, input logic [3:0] el);
    n_total++;
    if (o_led_r === er && o_leds === el) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got led_r=%b leds=%b, expected led_r=%b leds=%b",
               name, o_led_r, o_leds, er, el);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Expected leds bank for pattern word k.
  function automatic logic [3:0] wl(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return 4'b0001 << kk[1:0];
  endfunction

  initial begin
    // Run table: edge n after enable is sampled in IDLE. Edge 1 enters RUN
    // (outputs still 0); from edge 2 each word is shown for 4 edges.
    for (int n = 1; n <= 70; n++) begin
      tbl[n-1].en = 1'b1;
      if (n == 1) begin
        tbl[n-1].r = 4'd0;
        tbl[n-1].l = 4'd0;
      end else begin
        tbl[n-1].r = 4'(((n - 2) / 4) % 16);
        tbl[n-1].l = wl(((n - 2) / 4) % 16);
      end
    end

    i_reset  = 1'b1;
    i_enable = 1'b0;
    @(negedge clock);

    // Reset held for 3 edges: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      check("reset_hold", 4'd0, 4'd0);
      step();
    end
    i_reset = 1'b0;

    // 16 INIT cycles plus IDLE with enable low: outputs stay 0.
    for (int i = 0; i < 30; i++) begin
      step();
      check($sformatf("init_idle%0d", i), 4'd0, 4'd0);
    end

    // Main sequence, including the 15 -> 0 wrap around edges 65/66.
    for (int i = 0; i < 70; i++) begin
      i_enable = tbl[i].en;
      step();
      check($sformatf("run%0d", i + 1), tbl[i].r, tbl[i].l);
    end

    // Edge 71: word 1, second-to-last prescale count.
    step();
    check("run71", 4'd1, 4'b0010);

    // Enable drops: edge 72 still a RUN edge (3rd edge of word 1), then frozen.
    i_enable = 1'b0;
    step();
    check("hold_entry", 4'd1, 4'b0010);
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("hold%0d", i), 4'd1, 4'b0010);
    end

    // Resume: HOLD->RUN edge keeps word 1, one more RUN edge finishes its dwell.
    i_enable = 1'b1;
    step();
    check("resume_edge", 4'd1, 4'b0010);
    step();
    check("resume_last_w1", 4'd1, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("resume_w2_%0d", i), 4'd2, 4'b0100);
    end
    step();
    check("resume_w3", 4'd3, 4'b1000);

    // Asynchronous reset mid-RUN: outputs clear before the next rising edge.
    #2;
    i_reset  = 1'b1;
    i_enable = 1'b0;
    #1;
    check("async_reset", 4'd0, 4'd0);
    @(negedge clock);
    check("reset_mid_run", 4'd0, 4'd0);
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("reinit%0d", i), 4'd0, 4'd0);
    end
    i_enable = 1'b1;
    step();
    check("restart_edge1", 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("restart_w0_%0d", i), 4'd0, 4'b0001);
    end
    step();
    check("restart_w1", 4'd1, 4'b0010);

    // Enable held high through reset release: word 0 exactly on edge 18.
    i_reset  = 1'b1;
    i_enable = 1'b1;
    step();
    i_reset = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      check($sformatf("en_init_edge%0d", i), 4'd0, 4'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("en_init_w0_%0d", i), 4'd0, 4'b0001);
    end
    step();
    check("en_init_w1", 4'd1, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
